// File: rtl/debug_event_snapshot.sv
// Live hit/miss/context-switch event counters with host-triggered shadow
// snapshot and a registered select mux feeding the debug read PIO.
module debug_event_snapshot #(
    parameter int CNT_WIDTH = 32,
    parameter int SEQ_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        hit_pulse,
    input  logic        miss_pulse,
    input  logic        ctx_pulse,
    input  logic        snap_req,
    input  logic [1:0]  sel,
    output logic [31:0] out_word,
    output logic        snap_valid
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);

    logic [CNT_WIDTH-1:0] live     [3];
    logic [CNT_WIDTH-1:0] shadow   [3];
    logic [CNT_WIDTH-1:0] live_inc [3];
    logic [2:0]           pulse;
    logic [2:0]           sat;
    logic [2:0]           sat_hit;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 snap_req_d;
    logic                 snap_edge;
    logic [31:0]          word_next;

    assign pulse     = {ctx_pulse, miss_pulse, hit_pulse};
    assign snap_edge = snap_req & ~snap_req_d;

    // live_inc is the saturated post-increment value, ignoring clr
    always_comb begin
        sat_hit  = '0;
        live_inc = live;
        for (int i = 0; i < 3; i++) begin
            sat_hit[i] = pulse[i] && (live[i] == CNT_MAX);
            if (pulse[i] && !sat_hit[i]) begin
                live_inc[i] = live[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        word_next = '0;
        unique case (sel)
            2'd0:    word_next = 32'(shadow[0]);
            2'd1:    word_next = 32'(shadow[1]);
            2'd2:    word_next = 32'(shadow[2]);
            default: word_next = {24'(seq), 4'b0000, snap_valid, sat};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            sat        <= '0;
            seq        <= '0;
            snap_req_d <= 1'b0;
            out_word   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_req_d <= snap_req;
            out_word   <= word_next;
            for (int i = 0; i < 3; i++) begin
                live[i] <= clr ? '0 : live_inc[i];
                if (snap_edge) begin
                    shadow[i] <= live_inc[i];
                end
            end
            sat <= clr ? 3'b000 : (sat | sat_hit);
            if (snap_edge) begin
                seq        <= seq + SEQ_ONE;
                snap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_event_snapshot.sv
// Bench for debug_event_snapshot: 32-bit and 4-bit counter instances share
// stimulus and are checked against a true-count reference model.
module tb_debug_event_snapshot;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        ctx_pulse;
    logic        snap_req;
    logic [1:0]  sel;
    logic [31:0] out_word;
    logic        snap_valid;
    logic [31:0] out_word4;
    logic        snap_valid4;

    always #5 clk = ~clk;

    debug_event_snapshot #(.CNT_WIDTH(32), .SEQ_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .ctx_pulse  (ctx_pulse),
        .snap_req   (snap_req),
        .sel        (sel),
        .out_word   (out_word),
        .snap_valid (snap_valid)
    );

    debug_event_snapshot #(.CNT_WIDTH(4), .SEQ_WIDTH(8)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .ctx_pulse  (ctx_pulse),
        .snap_req   (snap_req),
        .sel        (sel),
        .out_word   (out_word4),
        .snap_valid (snap_valid4)
    );

    localparam longint M32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint M4  = 64'd15;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: true event count since last clr; live = min(count, max),
    // sat = count exceeded max.
    longint tc   [3];
    longint sh32 [3];
    longint sh4  [3];
    int     seq_m;
    bit     valid_m;
    bit     prev_snap;

    typedef struct {
        bit          h;
        bit          m;
        bit          c;
        bit          s;
        bit          k;
        bit [1:0]    sl;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            tc[i]   = 0;
            sh32[i] = 0;
            sh4[i]  = 0;
        end
        seq_m     = 0;
        valid_m   = 1'b0;
        prev_snap = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input bit [1:0] s, input longint m);
        logic [31:0] w;
        bit   [2:0]  st;
        if (s != 2'd3) begin
            w = (m == M4) ? 32'(sh4[s]) : 32'(sh32[s]);
        end else begin
            for (int i = 0; i < 3; i++) st[i] = tc[i] > m;
            w = {24'(seq_m), 4'b0000, valid_m, st};
        end
        return w;
    endfunction

    task automatic cycle(input bit h, input bit m, input bit c,
                         input bit s, input bit k, input bit [1:0] sl);
        logic [31:0] e32;
        logic [31:0] e4;
        bit   [2:0]  p;
        bit          edge_now;
        longint      tn;
        @(negedge clk);
        hit_pulse  = h;
        miss_pulse = m;
        ctx_pulse  = c;
        snap_req   = s;
        clr        = k;
        sel        = sl;
        e32 = model_word(sl, M32);
        e4  = model_word(sl, M4);
        p = {c, m, h};
        edge_now = s && !prev_snap;
        for (int i = 0; i < 3; i++) begin
            tn = tc[i] + longint'(p[i]);
            if (edge_now) begin
                sh32[i] = (tn > M32) ? M32 : tn;
                sh4[i]  = (tn > M4) ? M4 : tn;
            end
            tc[i] = k ? 0 : tn;
        end
        if (edge_now) begin
            seq_m   = (seq_m + 1) % 256;
            valid_m = 1'b1;
        end
        prev_snap = s;
        @(posedge clk);
        #1;
        check("out32", out_word, e32);
        check("valid32", 32'(snap_valid), 32'(valid_m));
        check("out4", out_word4, e4);
        check("valid4", 32'(snap_valid4), 32'(valid_m));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        clr        = 1'b0;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        ctx_pulse  = 1'b0;
        snap_req   = 1'b0;
        sel        = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_out32", out_word, 32'h0);
        check("rst_valid32", 32'(snap_valid), 32'h0);
        check("rst_out4", out_word4, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1, 1, 1, 0, 0, 2'd0, 32'h0};
        tbl[1] = '{1, 1, 0, 0, 0, 2'd0, 32'h0};
        tbl[2] = '{1, 1, 0, 0, 0, 2'd0, 32'h0};
        tbl[3] = '{1, 0, 0, 0, 0, 2'd0, 32'h0};
        tbl[4] = '{1, 0, 0, 0, 0, 2'd0, 32'h0};
        tbl[5] = '{0, 0, 0, 1, 0, 2'd3, 32'h0};
        tbl[6] = '{0, 0, 0, 1, 0, 2'd0, 32'd5};
        tbl[7] = '{0, 0, 0, 0, 0, 2'd1, 32'd3};
        tbl[8] = '{0, 0, 0, 0, 0, 2'd2, 32'd1};
        tbl[9] = '{0, 0, 0, 0, 0, 2'd3, 32'h0000_0108};

        reset = 1'b1;
        clr = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0; ctx_pulse = 1'b0;
        snap_req = 1'b0; sel = 2'd0;
        model_reset();
        #2;
        check("async_rst_out", out_word, 32'h0);
        check("async_rst_valid", 32'(snap_valid), 32'h0);
        apply_reset();

        // basic count, snapshot and readback
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].h, tbl[i].m, tbl[i].c, tbl[i].s, tbl[i].k, tbl[i].sl);
            check($sformatf("tbl%0d", i), out_word, tbl[i].exp);
        end

        // held snap_req takes one snapshot; hit on the edge cycle counts
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0, 2'd0);
        cycle(1, 0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 1, 0, 2'd0);
        check("hold_shadow", out_word, 32'd8);
        cycle(0, 0, 0, 1, 0, 2'd3);
        check("hold_seq", out_word, 32'h0000_0108);
        cycle(0, 0, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 2'd0);
        cycle(0, 0, 0, 0, 0, 2'd0);
        check("resnap_shadow", out_word, 32'd17);

        // clr together with the snapshot edge
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 2'd1);
        cycle(0, 1, 0, 1, 1, 2'd1);
        cycle(0, 0, 0, 0, 0, 2'd1);
        check("clr_snap_shadow", out_word, 32'd5);
        cycle(0, 0, 0, 1, 0, 2'd1);
        cycle(0, 0, 0, 0, 0, 2'd1);
        check("clr_after_snap", out_word, 32'd0);

        // saturation on the 4-bit instance
        apply_reset();
        for (int i = 0; i < 17; i++) cycle(1, 0, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 2'd0);
        cycle(0, 0, 0, 0, 0, 2'd0);
        check("sat4_shadow", out_word4, 32'h0000_000F);
        check("nosat32_shadow", out_word, 32'd17);
        cycle(0, 0, 0, 0, 0, 2'd3);
        check("sat4_status", out_word4, 32'h0000_0109);
        cycle(0, 0, 0, 0, 1, 2'd3);
        cycle(0, 0, 0, 0, 0, 2'd3);
        check("sat4_cleared", out_word4, 32'h0000_0108);

        // sequence wrap, then asynchronous reset mid-snapshot
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(0, 0, 0, 1, 0, 2'd3);
            cycle(0, 0, 0, 0, 0, 2'd3);
        end
        cycle(0, 0, 0, 0, 0, 2'd3);
        check("seq_wrap", out_word, 32'h0000_0008);
        cycle(1, 1, 1, 1, 0, 2'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        clr = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0; ctx_pulse = 1'b0;
        snap_req = 1'b0; sel = 2'd3;
        #1;
        check("mid_rst_out32", out_word, 32'h0);
        check("mid_rst_valid32", 32'(snap_valid), 32'h0);
        check("mid_rst_out4", out_word4, 32'h0);
        check("mid_rst_valid4", 32'(snap_valid4), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 2'd3);
        check("post_rst_status", out_word, 32'h0);

        // randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_event_snapshot.md
Name: debug_event_snapshot

Overview:
- Upstream feeder for the 32-bit debug read PIO in the cache-switching debug module; its out_word drives the PIO's in_port.
- Counts cache hit, cache miss and OS context-switch event pulses in live counters.
- On a host snapshot request, copies the live counters into shadow registers so the host reads a coherent set.
- A host-driven select picks which shadow value, or a status word, appears on out_word.

Parameters:
- CNT_WIDTH, 32: width of each live/shadow counter, 1..32. Zero-extended onto out_word.
- SEQ_WIDTH, 8: width of the snapshot sequence counter, 1..24.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of the live counters and saturation flags.
- hit_pulse  in  1  one cache hit per cycle high.
- miss_pulse  in  1  one cache miss per cycle high.
- ctx_pulse  in  1  one context switch per cycle high.
- snap_req  in  1  level from the host output PIO; its rising edge requests a snapshot.
- sel  in  2  output select: 0 hit, 1 miss, 2 ctx, 3 status.
- out_word  out  32  registered selected word, to the PIO in_port.
- snap_valid  out  1  high once at least one snapshot has been taken since reset.

Behaviour:
- Reset (asynchronous, active-high) zeroes:
  - the live counters, shadow counters and sticky saturation flags sat[2:0];
  - seq, the snap_req delay flop, out_word and snap_valid.
- Live counters:
  - Each counter increments by 1 on a cycle where its pulse is high.
  - Counters saturate at all-ones and never wrap.
  - An increment attempted while the counter is at all-ones sets its sat bit (hit = bit 0, miss = 1, ctx = 2). The sat bit stays set until clr or reset.
- clr:
  - Zeroes the live counters and sat[2:0] on the next edge.
  - clr wins over a same-cycle pulse: the counter ends at 0.
  - Shadows, seq and snap_valid are not affected.
- Snapshot edge detect:
  - snap_edge = snap_req & ~snap_req_d, where snap_req_d is registered.
  - snap_req is from a same-clock PIO and needs no synchronizer.
- On a snap_edge cycle:
  - Each shadow loads the live value including that cycle's increment, with saturation applied. This is the value the live counter would hold absent clr.
  - If clr is also high, the shadow still takes that pre-clear value and the live counters then clear.
  - seq increments, wrapping modulo 2^SEQ_WIDTH.
  - snap_valid is set and stays set until reset.
  - No snap_req edge leaves the shadows holding their values indefinitely.
- out_word: registered every cycle with 1-cycle latency from sel or a shadow change.
  - sel 0/1/2: the corresponding shadow, zero-extended to 32 bits.
  - sel 3, status word:
    - [31:8] = seq, zero-extended within the field;
    - [7:4] = 0;
    - [3] = snap_valid;
    - [2:0] = live sat flags (not shadowed).
- The downstream PIO adds one more register, so the host sees data 2 cycles after sel/snap; the host waits at least 2 cycles.
- Simultaneous pulses on all three inputs: each counter increments independently in the same cycle.
- Reset mid-count or mid-snapshot: all state returns to the reset values immediately; no partial snapshot survives.

Test Plan:
- Reset → out_word=0, snap_valid=0. Pulse hit 5×, miss 3×, ctx 1×, then raise snap_req → snap_valid=1. Read back: sel=0 → 5, sel=1 → 3, sel=2 → 1, sel=3 → 0x00000108.
- Hold snap_req high for 10 cycles while pulsing hit → only one snapshot taken (seq=1). Shadow does not track further hits until snap_req drops and rises again.
- Hit pulse on the same cycle as the snap_req rising edge, live hit=7 → shadow hit=8.
- clr on the same cycle as the snap edge, live miss=4 with a miss pulse → shadow miss=5, live miss=0 next cycle, and a subsequent snapshot with no events gives 0.
- CNT_WIDTH=4: 17 hit pulses → live hit=15 with sat[0]=1. Snapshot then sel=0 → 0x0000000F; sel=3 → bit0=1. clr → sat cleared.
- 256 snapshots with SEQ_WIDTH=8 → seq wraps to 0; status [31:8]=0 and [3]=1. Assert reset mid-sequence → all outputs 0 on the same edge, without waiting for a clock.
